// File: rtl/fsk_pkg.sv
// Shared definitions for the framed FSK transmitter.
//   - fsk_state_e : framing FSM state encoding
//   - tone_sel_e  : tone selector driven into the tone generator
//   - DEF_*       : default parameter values for fsk_framed_tx
package fsk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } fsk_state_e;

  typedef enum logic [1:0] {
    TONE_OFF   = 2'd0,
    TONE_MARK  = 2'd1,
    TONE_SPACE = 2'd2
  } tone_sel_e;

  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_BIT_CYCLES = 26042;
  localparam int unsigned DEF_MARK_DIV   = 96;
  localparam int unsigned DEF_SPACE_DIV  = 104;
  localparam bit          DEF_FRAMED     = 1'b1;
  localparam bit          DEF_MSB_FIRST  = 1'b0;
  localparam bit          DEF_IDLE_TONE  = 1'b0;

endpackage

// File: rtl/fsk_tone_gen.sv
// Phase-continuous FSK square-wave generator.
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   tone_sel   : tone to emit on the NEXT cycle (lets tone_out change on the same
//                edge as the registered mark/space enables in the parent)
//   mark_div   : mark half-period in clk cycles (>= 1)
//   space_div  : space half-period in clk cycles (>= 1)
//   tone_out   : registered square wave, 0 while the tone is off
module fsk_tone_gen
  import fsk_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  tone_sel_e        tone_sel,
  input  logic [DIV_W-1:0] mark_div,
  input  logic [DIV_W-1:0] space_div,
  output logic             tone_out
);

  tone_sel_e        sel_q, sel_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tone_q, tone_d;
  logic [DIV_W-1:0] div;

  always_comb begin
    sel_d  = tone_sel;
    cnt_d  = cnt_q;
    tone_d = tone_q;
    div    = (sel_q == TONE_SPACE) ? space_div : mark_div;

    if (tone_sel == TONE_OFF) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (tone_sel != sel_q) begin
      // Tone change: restart the half period but keep the level, so the
      // phase in progress is stretched rather than cut short.
      cnt_d  = '0;
      tone_d = tone_q;
    end else if (cnt_q == div - 1'b1) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sel_q  <= TONE_OFF;
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone_out = tone_q;

endmodule

// File: rtl/fsk_framed_tx.sv
// Framed FSK transmitter: accepts a DATA_W-bit word on valid_in & ready and sends it
// as optional start bit (space), data bits (1 = mark, 0 = space) and optional stop
// bit (mark), each bit lasting BIT_CYCLES clocks.
// Ports:
//   clk, rstn   : clock, synchronous active-low reset
//   data_in     : payload, sampled only on acceptance
//   valid_in    : payload valid (ignored while busy)
//   ready       : can accept a frame
//   tone_out    : FSK square wave
//   mark_en     : current bit is mark
//   space_en    : current bit is space
//   busy        : frame in progress
//   bit_strobe  : one-cycle pulse on the first cycle of each bit
module fsk_framed_tx
  import fsk_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int unsigned MARK_DIV   = DEF_MARK_DIV,
  parameter int unsigned SPACE_DIV  = DEF_SPACE_DIV,
  parameter bit          FRAMED     = DEF_FRAMED,
  parameter bit          MSB_FIRST  = DEF_MSB_FIRST,
  parameter bit          IDLE_TONE  = DEF_IDLE_TONE
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready,
  output logic              tone_out,
  output logic              mark_en,
  output logic              space_en,
  output logic              busy,
  output logic              bit_strobe
);

  if (BIT_CYCLES < 2) begin : gen_bad_bit_cycles
    $error("fsk_framed_tx: BIT_CYCLES must be >= 2");
  end
  if (MARK_DIV < 1) begin : gen_bad_mark_div
    $error("fsk_framed_tx: MARK_DIV must be >= 1");
  end
  if (SPACE_DIV < 1) begin : gen_bad_space_div
    $error("fsk_framed_tx: SPACE_DIV must be >= 1");
  end
  if (DATA_W < 1) begin : gen_bad_data_w
    $error("fsk_framed_tx: DATA_W must be >= 1");
  end

  localparam int unsigned CYC_W   = $clog2(BIT_CYCLES);
  localparam int unsigned BCNT_W  = $clog2(DATA_W + 3);
  localparam int unsigned MAX_DIV = (MARK_DIV > SPACE_DIV) ? MARK_DIV : SPACE_DIV;
  localparam int unsigned DIV_W   = $clog2(MAX_DIV + 1);

  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_W - 1);

  fsk_state_e        state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              strobe_q, strobe_d;
  logic              mark_q, mark_d;
  logic              space_q, space_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              head_d;
  tone_sel_e         tone_sel_d;

  // Framing FSM: next state, counters and shift register.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    strobe_d = 1'b0;

    if (state_q == StIdle) begin
      if (valid_in && ready_q) begin
        state_d  = FRAMED ? StStart : StData;
        cyc_d    = '0;
        bcnt_d   = '0;
        shreg_d  = data_in;
        strobe_d = 1'b1;
      end
    end else if (cyc_q != CYC_LAST) begin
      cyc_d = cyc_q + 1'b1;
    end else begin
      cyc_d    = '0;
      strobe_d = 1'b1;
      unique case (state_q)
        StStart: state_d = StData;
        StData: begin
          if (bcnt_q == BCNT_LAST) begin
            state_d  = FRAMED ? StStop : StIdle;
            strobe_d = FRAMED;
          end else begin
            bcnt_d  = bcnt_q + 1'b1;
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          end
        end
        StStop: begin
          state_d  = StIdle;
          strobe_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    head_d  = MSB_FIRST ? shreg_d[DATA_W-1] : shreg_d[0];
    mark_d  = 1'b0;
    space_d = 1'b0;
    unique case (state_d)
      StIdle:  mark_d  = IDLE_TONE;
      StStart: space_d = 1'b1;
      StData: begin
        mark_d  = head_d;
        space_d = ~head_d;
      end
      StStop:  mark_d  = 1'b1;
    endcase
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);

    if (mark_d) begin
      tone_sel_d = TONE_MARK;
    end else if (space_d) begin
      tone_sel_d = TONE_SPACE;
    end else begin
      tone_sel_d = TONE_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cyc_q    <= '0;
      bcnt_q   <= '0;
      shreg_q  <= '0;
      strobe_q <= 1'b0;
      mark_q   <= 1'b0;
      space_q  <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bcnt_q   <= bcnt_d;
      shreg_q  <= shreg_d;
      strobe_q <= strobe_d;
      mark_q   <= mark_d;
      space_q  <= space_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // While rstn is low the generator is held in reset, so the selector is don't-care.
  fsk_tone_gen #(
    .DIV_W (DIV_W)
  ) u_tone_gen (
    .clk       (clk),
    .rstn      (rstn),
    .tone_sel  (tone_sel_d),
    .mark_div  (DIV_W'(MARK_DIV)),
    .space_div (DIV_W'(SPACE_DIV)),
    .tone_out  (tone_out)
  );

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign bit_strobe = strobe_q;
  assign mark_en    = mark_q;
  assign space_en   = space_q;

endmodule

// File: tb/tb_fsk_framed_tx.sv
// Bench for fsk_framed_tx. Two instances share clk/rstn:
//   dut  : FRAMED=1, LSB first, silent idle
//   dut2 : FRAMED=0, MSB first, mark tone while idle
// Outputs are sampled 1 time unit after each rising edge; inputs are driven then too.
module tb_fsk_framed_tx;

  localparam int BC   = 16;
  localparam int MDIV = 2;
  localparam int SDIV = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] d1, d2;
  logic       v1, v2;
  logic       rdy1, tone1, mk1, sp1, bsy1, stb1;
  logic       rdy2, tone2, mk2, sp2, bsy2, stb2;

  int n_cmp = 0;
  int n_bad = 0;
  logic trace [0:200];

  always #5 clk = ~clk;

  fsk_framed_tx #(
    .DATA_W(8), .BIT_CYCLES(BC), .MARK_DIV(MDIV), .SPACE_DIV(SDIV),
    .FRAMED(1'b1), .MSB_FIRST(1'b0), .IDLE_TONE(1'b0)
  ) dut (
    .clk(clk), .rstn(rstn), .data_in(d1), .valid_in(v1), .ready(rdy1),
    .tone_out(tone1), .mark_en(mk1), .space_en(sp1), .busy(bsy1), .bit_strobe(stb1)
  );

  fsk_framed_tx #(
    .DATA_W(8), .BIT_CYCLES(BC), .MARK_DIV(MDIV), .SPACE_DIV(SDIV),
    .FRAMED(1'b0), .MSB_FIRST(1'b1), .IDLE_TONE(1'b1)
  ) dut2 (
    .clk(clk), .rstn(rstn), .data_in(d2), .valid_in(v2), .ready(rdy2),
    .tone_out(tone2), .mark_en(mk2), .space_en(sp2), .busy(bsy2), .bit_strobe(stb2)
  );

  // {ready, busy, bit_strobe, mark_en, space_en, tone_out}
  function automatic logic [5:0] obs(input int sel);
    return (sel == 0) ? {rdy1, bsy1, stb1, mk1, sp1, tone1}
                      : {rdy2, bsy2, stb2, mk2, sp2, tone2};
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      v1 = v; d1 = d;
    end else begin
      v2 = v; d2 = d;
    end
  endtask

  // Reference: level of bit position idx within a frame of the given instance.
  function automatic logic exp_bit(input int sel, input logic [7:0] data, input int idx);
    if (sel == 0) begin
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return data[idx-1];
    end
    return data[7-idx];
  endfunction

  task automatic test_reset();
    logic [5:0] got, exp;
    rstn = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        got = obs(s);
        n_cmp++;
        if (got !== 6'b000000) begin
          n_bad++;
          $display("FAIL reset_hold dut%0d cyc%0d: got %b required 000000", s, i, got);
        end
      end
    end
    rstn = 1'b1;
    // dut2 idles on mark: tone starts low and toggles every MDIV cycles.
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      got = obs(0);
      n_cmp++;
      if (got !== 6'b100000) begin
        n_bad++;
        $display("FAIL release_idle dut0 k%0d: got %b required 100000", k, got);
      end
      got = obs(1);
      exp = {5'b10010, (((k / MDIV) % 2) == 1)};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL release_idle_tone dut1 k%0d: got %b required %b", k, got, exp);
      end
    end
  endtask

  // Send one frame starting in the current cycle (ready must be high) and check every
  // cycle through the first idle cycle. With hammer set, valid stays high with new
  // random data every cycle of the frame.
  task automatic test_frame(input int sel, input logic [7:0] data, input bit hammer);
    int   nbits, n, idx, run, cur, prev;
    logic b, lvl, start_lvl, tone_m;
    logic [5:0] got, exp;
    nbits = (sel == 0) ? 10 : 8;
    n     = nbits * BC;
    got   = obs(sel);
    n_cmp++;
    if (got[5] !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_ready dut%0d: got %b required 1", sel, got[5]);
    end
    drive(sel, 1'b1, data);
    prev = 0; lvl = 1'b0; start_lvl = 1'b0; run = 0;
    for (int t = 1; t <= n; t++) begin
      @(posedge clk); #1;
      drive(sel, hammer, 8'($urandom));
      idx = (t - 1) / BC;
      b   = exp_bit(sel, data, idx);
      cur = b ? 1 : 2;
      if (cur != prev) begin
        start_lvl = lvl;
        run = 0;
      end
      tone_m = start_lvl ^ (((run / (b ? MDIV : SDIV)) % 2) == 1);
      lvl  = tone_m;
      run++;
      prev = cur;
      exp = {1'b0, 1'b1, ((t - 1) % BC) == 0, b, ~b, tone_m};
      got = obs(sel);
      if (sel != 0) begin
        // dut2's tone is continuous across idle and is checked elsewhere.
        exp[0] = 1'b0;
        got[0] = 1'b0;
      end
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL frame dut%0d data %02h t%0d: got %b required %b", sel, data, t, got,
                 exp);
      end
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 8'h00);
    exp = {3'b100, (sel != 0), 2'b00};
    got = obs(sel);
    if (sel != 0) got[0] = 1'b0;
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL frame_end dut%0d data %02h: got %b required %b", sel, data, got, exp);
    end
  endtask

  task automatic capture1(input logic [7:0] data);
    drive(0, 1'b1, data);
    trace[0] = 1'b0;
    for (int t = 1; t <= 161; t++) begin
      @(posedge clk); #1;
      drive(0, 1'b0, 8'h00);
      trace[t] = tone1;
    end
  endtask

  task automatic test_tone_period();
    int last, bad, edges, mn, tog;
    // All-ones: start bit then 144 cycles of mark, period 2*MDIV.
    capture1(8'hFF);
    last = 0; bad = 0; edges = 0;
    for (int t = 18; t <= 160; t++) begin
      if (!trace[t-1] && trace[t]) begin
        if (last != 0 && t - last != 2 * MDIV) bad = t - last;
        last = t;
        edges++;
      end
    end
    n_cmp++;
    if (bad != 0 || edges < 30) begin
      n_bad++;
      $display("FAIL mark_period: spacing %0d edges %0d required spacing %0d edges >= 30",
               bad, edges, 2 * MDIV);
    end
    // All-zeros: 144 cycles of space, period 2*SDIV.
    capture1(8'h00);
    last = 0; bad = 0; edges = 0;
    for (int t = 2; t <= 144; t++) begin
      if (!trace[t-1] && trace[t]) begin
        if (last != 0 && t - last != 2 * SDIV) bad = t - last;
        last = t;
        edges++;
      end
    end
    n_cmp++;
    if (bad != 0 || edges < 20) begin
      n_bad++;
      $display("FAIL space_period: spacing %0d edges %0d required spacing %0d edges >= 20",
               bad, edges, 2 * SDIV);
    end
    // Mixed pattern: no interior phase shorter than the shorter half period.
    capture1(8'hA5);
    last = 0; mn = 1000; tog = 0;
    for (int t = 2; t <= 160; t++) begin
      if (trace[t] !== trace[t-1]) begin
        if (last != 0 && t - last < mn) mn = t - last;
        last = t;
        tog++;
      end
    end
    n_cmp++;
    if (mn < MDIV || tog < 20) begin
      n_bad++;
      $display("FAIL min_phase: shortest %0d toggles %0d required >= %0d and >= 20", mn, tog,
               MDIV);
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] got;
    int bad;
    drive(0, 1'b1, 8'($urandom));
    for (int t = 1; t <= 1 + 3 * BC; t++) begin
      @(posedge clk); #1;
      drive(0, 1'b0, 8'h00);
    end
    n_cmp++;
    if ({bsy1, stb1} !== 2'b11) begin
      n_bad++;
      $display("FAIL strobe4: got busy/strobe %b required 11", {bsy1, stb1});
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      got = obs(s);
      n_cmp++;
      if (got !== 6'b000000) begin
        n_bad++;
        $display("FAIL abort dut%0d: got %b required 000000", s, got);
      end
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    got = obs(0);
    n_cmp++;
    if (got !== 6'b100000) begin
      n_bad++;
      $display("FAIL abort_release: got %b required 100000", got);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bsy1 !== 1'b0 || rdy1 !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL no_resume: %0d cycles busy or not ready, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    // Reference patterns.
    test_frame(0, 8'hA5, 1'b0);
    test_frame(1, 8'h80, 1'b0);
    // Valid held with changing data while busy, then an immediate next frame.
    test_frame(0, 8'($urandom), 1'b1);
    test_frame(0, 8'($urandom), 1'b0);
    // Back-to-back random frames on both configurations.
    for (int i = 0; i < 4; i++) test_frame(0, 8'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++) test_frame(1, 8'($urandom), 1'($urandom));
    test_tone_period();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
